// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: memory-side responder for the core data bus.
// A doubleword RAM mapped at BASE answers each request after a fixed latency;
// writes are byte-strobed and take effect on the edge that enters RESP.
// Optional macro DBUS_RESP_RANDLAT_EN adds 0..3 cycles of LFSR-driven latency.
`timescale 1ns/1ps

module dbus_mem_responder #(
    parameter int          DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [63:0] dreq_data,
    input  logic [7:0]  dreq_strobe,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DBUS_RESP_RANDLAT_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [CW-1:0] eff_lat;
    logic          accept, commit;

    logic [63:0]   lat_addr, lat_data;
    logic [7:0]    lat_strobe;
    logic [63:0]   cur_addr, cur_data;
    logic [7:0]    cur_strobe;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [2:0]    size_seen;

    logic [63:0]   mem [DEPTH];

    // Access size is informational only; captured here so it is not left dangling
    assign size_seen = dreq_size & 3'b000;

`ifdef DBUS_RESP_RANDLAT_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR (x^8+x^6+x^5+x^4+1), stepped once per accepted request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign eff_lat = CW'(LATENCY) + CW'(lfsr[1:0]) + CW'(size_seen);
`else
    assign eff_lat = CW'(LATENCY) + CW'(size_seen);
`endif

    // In IDLE the live request is used (LATENCY==1 commits on the accept edge); later the latched copy
    always_comb begin
        cur_addr   = lat_addr;
        cur_data   = lat_data;
        cur_strobe = lat_strobe;
        if (state == IDLE) begin
            cur_addr   = dreq_addr;
            cur_data   = dreq_data;
            cur_strobe = dreq_strobe;
        end
        in_range = (cur_addr >= BASE) && (cur_addr < LIMIT);
        idx      = AW'((cur_addr - BASE) >> 3);
    end

    // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (dreq_valid) begin
                    accept = 1'b1;
                    if (eff_lat == CW'(1)) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = eff_lat - CW'(2);
                    end
                end
            end
            WAIT: begin
                if (!dreq_valid) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, request latch and registered response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_addr      <= '0;
            lat_data      <= '0;
            lat_strobe    <= '0;
            dresp_addr_ok <= 1'b0;
            dresp_data_ok <= 1'b0;
            dresp_data    <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            dresp_addr_ok <= (state_next == RESP);
            dresp_data_ok <= (state_next == RESP);
            if (accept) begin
                lat_addr   <= dreq_addr;
                lat_data   <= dreq_data;
                lat_strobe <= dreq_strobe;
            end
            if (commit) begin
                dresp_data <= in_range ? mem[idx] : 64'd0;
            end
        end
    end

    // Backing RAM write port; contents survive reset, out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (reset && commit && in_range && (cur_strobe != 8'd0)) begin
            for (int i = 0; i < 8; i++) begin
                if (cur_strobe[i]) begin
                    mem[idx][8*i +: 8] <= cur_data[8*i +: 8];
                end
            end
        end
    end

endmodule
